// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and helpers for the memory-port arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Requester-ID width; a single bit is kept even for one or two requesters
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First asserted request at or after ptr, wrapping at n
  function automatic int unsigned rr_winner(input logic [MAX_REQ-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
    int unsigned win;
    int unsigned idx;
    logic        found;
    win   = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && req[idx[2:0]]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_id_fifo.sv
// ============================================================================
// mem_arb_id_fifo : small in-order FIFO holding owner IDs of granted requests
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_arb_id_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : round-robin arbiter sharing one req/gnt/rvalid memory port
// Revision         : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         s_req_i,
  input  logic [NUM_REQ-1:0]         s_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  s_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]  s_wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] s_be_i,
  output logic [NUM_REQ-1:0]         s_gnt_o,
  output logic [NUM_REQ-1:0]         s_rvalid_o,
  output logic [DATA_W-1:0]          s_rdata_o,
  output logic                       m_req_o,
  output logic                       m_we_o,
  output logic [ADDR_W-1:0]          m_addr_o,
  output logic [DATA_W-1:0]          m_wdata_o,
  output logic [DATA_W/8-1:0]        m_be_o,
  input  logic                       m_gnt_i,
  input  logic                       m_rvalid_i,
  input  logic [DATA_W-1:0]          m_rdata_i,
  output logic                       err_o
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  arb_state_e         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    lock_idx;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    head;
  logic [MAX_REQ-1:0] req_pad;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               grant;
  logic               pop;

  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = s_req_i;
  end

  // A stalled winner keeps the port until the bridge accepts it
  assign winner = (state == LOCKED) ? lock_idx
                                    : ID_W'(rr_winner(req_pad, 32'(rr_ptr), NUM_REQ));

  // Gating with rst_ni keeps handshakes quiet for the whole reset window
  assign m_req_o   = rst_ni && (|s_req_i) && (fifo_count < CNT_W'(MAX_OUT));
  assign grant     = m_req_o && m_gnt_i;
  assign pop       = rst_ni && m_rvalid_i && !fifo_empty;
  assign s_rdata_o = m_rdata_i;

  always_comb begin
    m_we_o    = s_we_i[0];
    m_addr_o  = s_addr_i[ADDR_W-1:0];
    m_wdata_o = s_wdata_i[DATA_W-1:0];
    m_be_o    = s_be_i[BE_W-1:0];
    s_gnt_o    = '0;
    s_rvalid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (m_req_o && (winner == ID_W'(i))) begin
        m_we_o    = s_we_i[i];
        m_addr_o  = s_addr_i[i*ADDR_W +: ADDR_W];
        m_wdata_o = s_wdata_i[i*DATA_W +: DATA_W];
        m_be_o    = s_be_i[i*BE_W +: BE_W];
      end
      s_gnt_o[i]    = grant && (winner == ID_W'(i));
      s_rvalid_o[i] = pop && (head == ID_W'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= ARB;
      rr_ptr   <= '0;
      lock_idx <= '0;
      err_o    <= 1'b0;
    end else begin
      if (m_rvalid_i && fifo_empty) err_o <= 1'b1;
      if (grant) begin
        state  <= ARB;
        rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
      end else if (m_req_o) begin
        state    <= LOCKED;
        lock_idx <= winner;
      end
    end
  end

  mem_arb_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (grant),
    .push_data (winner),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  no_grant_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                        !(fifo_full && grant));

endmodule

`default_nettype wire
